// File: rtl/fp4_systolic_array_v2.sv
// FP4 (e3m0) / INT4 weight-stationary accumulator grid with a snapshot-and-drain readout.
// Input blocks arrive over SLICES beats; completed blocks fold into H x W accumulators one cycle later.
module fp4_systolic_array_v2 #(
    parameter int SLICES = 2,
    parameter int ACC_W  = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_left,
    input  logic [7:0] in_top,
    input  logic       mode,
    input  logic       restart_inputs,
    input  logic       read_start,
    input  logic [4:0] out_shift,
    input  logic       relu_en,
    input  logic       out_ready,
    output logic [7:0] out,
    output logic       out_valid,
    output logic       out_last,
    output logic       busy
);
    localparam int H  = 2 * SLICES;
    localparam int W  = SLICES;
    localparam int N  = H * W;
    localparam int BW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(8'sd127);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(8'sh80);

    typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

    function automatic logic signed [ACC_W-1:0] mul_fn(input logic [3:0] w, input logic [7:0] t,
                                                       input logic int_mode);
        logic signed [ACC_W-1:0] tx, wx, p;
        tx = {{(ACC_W-8){t[7]}}, t};
        wx = {{(ACC_W-4){w[3]}}, w};
        if (int_mode) begin
            p = wx * tx;
        end else if (w[2:0] == 3'd0) begin
            p = {ACC_W{1'b0}};
        end else begin
            p = (tx <<< w[2:0]) >>> 1'b1;
            p = w[3] ? -p : p;
        end
        return p;
    endfunction

    function automatic logic [7:0] fmt_fn(input logic signed [ACC_W-1:0] a, input logic [4:0] sh,
                                          input logic relu);
        logic signed [ACC_W-1:0] v;
        logic [7:0] r;
        v = a >>> sh;
        if (relu && v[ACC_W-1]) begin
            v = {ACC_W{1'b0}};
        end else begin
            v = v;
        end
        if (v > SAT_HI) begin
            r = 8'h7f;
        end else if (v < SAT_LO) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    logic [BW-1:0]           beat_r;
    logic [3:0]              left_r [H];
    logic [7:0]              top_r [W];
    logic [3:0]              left_s [H];
    logic [7:0]              top_s [W];
    logic [3:0]              blk_left_r [H];
    logic [7:0]              blk_top_r [W];
    logic                    blk_mode_r;
    logic                    upd_r;
    logic signed [ACC_W-1:0] acc_r [H][W];
    logic signed [ACC_W-1:0] sum_s [H][W];
    logic signed [ACC_W-1:0] q_r [N];
    state_t                  state_r;
    logic [NW-1:0]           idx_r;
    logic [NW-1:0]           nxt_s;
    logic                    take_s;
    logic                    done_s;
    logic                    snap_s;

    assign take_s = in_valid & ~restart_inputs;
    assign done_s = take_s & (beat_r == BW'(SLICES - 1));
    assign snap_s = (state_r == IDLE) & read_start;
    assign nxt_s  = idx_r + NW'(1);

    // Staged block contents with the current beat merged into its row pair and column.
    always_comb begin
        for (int k = 0; k < SLICES; k++) begin
            left_s[2*k]   = (take_s && beat_r == BW'(k)) ? in_left[3:0] : left_r[2*k];
            left_s[2*k+1] = (take_s && beat_r == BW'(k)) ? in_left[7:4] : left_r[2*k+1];
            top_s[k]      = (take_s && beat_r == BW'(k)) ? in_top : top_r[k];
        end
    end

    // Accumulator values including the pending block contribution.
    always_comb begin
        for (int i = 0; i < H; i++) begin
            for (int j = 0; j < W; j++) begin
                sum_s[i][j] = acc_r[i][j] + (upd_r ? mul_fn(blk_left_r[i], blk_top_r[j], blk_mode_r)
                                                   : {ACC_W{1'b0}});
            end
        end
    end

    // Beat index and partial-block staging.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_r <= {BW{1'b0}};
            for (int i = 0; i < H; i++) left_r[i] <= 4'd0;
            for (int j = 0; j < W; j++) top_r[j] <= 8'd0;
        end else if (restart_inputs) begin
            beat_r <= {BW{1'b0}};
        end else if (take_s) begin
            beat_r <= done_s ? {BW{1'b0}} : beat_r + BW'(1);
            left_r <= left_s;
            top_r  <= top_s;
        end else begin
            beat_r <= beat_r;
        end
    end

    // Completed-block capture so the next block can start while this one is applied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_r      <= 1'b0;
            blk_mode_r <= 1'b0;
            for (int i = 0; i < H; i++) blk_left_r[i] <= 4'd0;
            for (int j = 0; j < W; j++) blk_top_r[j] <= 8'd0;
        end else begin
            upd_r <= done_s;
            if (done_s) begin
                blk_left_r <= left_s;
                blk_top_r  <= top_s;
                blk_mode_r <= mode;
            end
        end
    end

    // Accumulators: fold in the pending block, or clear when snapshotted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < H; i++)
                for (int j = 0; j < W; j++) acc_r[i][j] <= {ACC_W{1'b0}};
        end else begin
            for (int i = 0; i < H; i++)
                for (int j = 0; j < W; j++) acc_r[i][j] <= snap_s ? {ACC_W{1'b0}} : sum_s[i][j];
        end
    end

    // Readout FSM: snapshot into the queue, then stream words under ready/valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            idx_r     <= {NW{1'b0}};
            out       <= 8'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            for (int n = 0; n < N; n++) q_r[n] <= {ACC_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (read_start) begin
                        for (int i = 0; i < H; i++)
                            for (int j = 0; j < W; j++) q_r[i*W+j] <= sum_s[i][j];
                        state_r   <= DRAIN;
                        busy      <= 1'b1;
                        idx_r     <= {NW{1'b0}};
                        out       <= fmt_fn(sum_s[0][0], out_shift, relu_en);
                        out_valid <= 1'b1;
                        out_last  <= (N == 1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (idx_r == NW'(N - 1)) begin
                            state_r   <= IDLE;
                            busy      <= 1'b0;
                            out       <= 8'd0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            idx_r    <= nxt_s;
                            out      <= fmt_fn(q_r[nxt_s], out_shift, relu_en);
                            out_last <= (nxt_s == NW'(N - 1));
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    out       <= 8'd0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp4_systolic_array_v2.sv
// Scoreboard bench: a behavioural accumulator model predicts every dump word; a monitor checks them.
module tb_fp4_systolic_array_v2;
    localparam int S  = 2;
    localparam int H  = 2 * S;
    localparam int W  = S;
    localparam int N  = H * W;
    localparam int AW = 24;

    logic       clk = 1'b0;
    logic       reset, in_valid, mode, restart_inputs, read_start, relu_en, out_ready;
    logic [7:0] in_left, in_top, out;
    logic [4:0] out_shift;
    logic       out_valid, out_last, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {logic [7:0] v; logic l;} exp_t;
    exp_t       sbq[$];
    longint     macc[H][W];
    logic [3:0] pl[H];
    int         pt[W];
    int         bidx;
    bit         bp_rand = 1'b0;
    bit         ready_force = 1'b1;

    fp4_systolic_array_v2 #(.SLICES(S), .ACC_W(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_left(in_left), .in_top(in_top),
        .mode(mode), .restart_inputs(restart_inputs), .read_start(read_start),
        .out_shift(out_shift), .relu_en(relu_en), .out_ready(out_ready), .out(out),
        .out_valid(out_valid), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic longint wrapv(input longint v);
        logic [AW-1:0] t;
        t = v[AW-1:0];
        return longint'($signed(t));
    endfunction

    function automatic longint ref_mul(input logic [3:0] w, input int top, input bit m);
        int e;
        longint mag;
        if (m) return longint'((w >= 4'd8 ? int'(w) - 16 : int'(w)) * top);
        e = int'(w[2:0]);
        if (e == 0) return 0;
        mag = longint'(top) * (longint'(1) << (e - 1));
        return w[3] ? -mag : mag;
    endfunction

    function automatic logic [7:0] ref_fmt(input longint a, input int sh, input bit relu);
        longint v;
        v = a >>> sh;
        if (relu && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) macc[i][j] = 0;
        bidx = 0;
    endfunction

    task automatic step(input bit v, input logic [7:0] l, input logic [7:0] t, input bit m, input bit rs);
        in_valid = v; in_left = l; in_top = t; mode = m; restart_inputs = rs;
        @(posedge clk); #1;
        in_valid = 1'b0; restart_inputs = 1'b0;
        if (rs) begin
            bidx = 0;
        end else if (v) begin
            pl[2*bidx] = l[3:0];
            pl[2*bidx+1] = l[7:4];
            pt[bidx] = int'($signed(t));
            if (bidx == S - 1) begin
                for (int i = 0; i < H; i++)
                    for (int j = 0; j < W; j++) macc[i][j] = wrapv(macc[i][j] + ref_mul(pl[i], pt[j], m));
                bidx = 0;
            end else begin
                bidx++;
            end
        end
    endtask

    task automatic block(input logic [7:0] l0, t0, l1, t1, input bit m);
        step(1'b1, l0, t0, 1'($urandom_range(0, 1)), 1'b0);
        step(1'b1, l1, t1, m, 1'b0);
    endtask

    task automatic rd(input int sh, input bit relu);
        out_shift = 5'(sh); relu_en = relu; read_start = 1'b1;
        for (int n = 0; n < N; n++) begin
            exp_t e;
            e.v = ref_fmt(macc[n / W][n % W], sh, relu);
            e.l = (n == N - 1);
            sbq.push_back(e);
        end
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) macc[i][j] = 0;
        @(posedge clk); #1;
        read_start = 1'b0;
        chk("word0_valid", out_valid, 1);
        chk("busy_drain", busy, 1);
    endtask

    task automatic drain();
        int k = 0;
        while (sbq.size() != 0 && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        if (sbq.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d words still expected", sbq.size());
            sbq.delete();
        end
        @(posedge clk); #1;
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_out", out, 0);
    endtask

    // Ready driver: forced level or random backpressure, changed well clear of both edges.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            out_ready = bp_rand ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Monitor: every presented word must match the queue head; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word: got %0d expected none", out);
                end else begin
                    chk("out_word", out, sbq[0].v);
                    chk("out_last", out_last, sbq[0].l);
                    if (out_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_left = 8'd0; in_top = 8'd0; mode = 1'b0;
        restart_inputs = 1'b0; read_start = 1'b0; out_shift = 5'd0; relu_en = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out", out, 0);
        reset = 1'b0;
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

        // FP4 e=3 rows; read_start lands on the accumulate cycle
        block(8'h33, 8'd10, 8'h33, 8'hFD, 1'b0);
        rd(0, 1'b0); drain();
        // FP4 sign/zero exponent
        block(8'h98, 8'd5, 8'h98, 8'd5, 1'b0);
        repeat (3) step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        rd(0, 1'b0); drain();
        // INT4 saturation, then shifted
        block(8'hFF, 8'h80, 8'hFF, 8'h80, 1'b1);
        rd(0, 1'b0); drain();
        block(8'hFF, 8'h80, 8'hFF, 8'h80, 1'b1);
        rd(1, 1'b0); drain();
        // ReLU
        block(8'h33, 8'd10, 8'h33, 8'hFD, 1'b0);
        rd(0, 1'b1); drain();

        // Backpressure hold, ignored read_start, block during drain
        block(8'h33, 8'd10, 8'h33, 8'hFD, 1'b0);
        rd(0, 1'b0);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        ready_force = 1'b0;
        read_start = 1'b1;
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        read_start = 1'b0;
        block(8'h5A, 8'd7, 8'hC1, 8'hF0, 1'b1);
        ready_force = 1'b1;
        drain();
        rd(0, 1'b0); drain();

        // Randomized blocks, restarts, shifts and backpressure
        bp_rand = 1'b1;
        for (int it = 0; it < 8; it++) begin
            int nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
                    step(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
                end
                block(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            end
            if ($urandom_range(0, 1) == 1) step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
            rd($urandom_range(0, 9), 1'($urandom));
            drain();
        end
        bp_rand = 1'b0;
        ready_force = 1'b1;

        // Reset mid-readout, beats ignored during reset, then restart after one beat
        block(8'h77, 8'd100, 8'h77, 8'd90, 1'b0);
        rd(0, 1'b0);
        repeat (2) step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_out", out, 0);
        chk("rst_mid_last", out_last, 0);
        sbq.delete();
        model_clear();
        in_valid = 1'b1; in_left = 8'h44; in_top = 8'd9; read_start = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; read_start = 1'b0;
        reset = 1'b0;
        chk("rst_no_read", out_valid, 0);
        step(1'b1, 8'hAB, 8'd7, 1'b0, 1'b0);
        step(1'b1, 8'hCD, 8'd3, 1'b1, 1'b1);
        block(8'h21, 8'd3, 8'h43, 8'hFE, 1'b0);
        rd(0, 1'b0); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
